// File: rtl/button_conditioner.sv
// Purpose: synchronise, debounce and edge-detect raw push-button pad levels, one FSM per button.
// Latency: level/press follow a stable input by DEBOUNCE_CYCLES+2 clock edges (2 sync + qualify).
// Backpressure: none; free-running, outputs are registered and advance every cycle.
module button_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_BTN-1:0] BTN_IN,
  output logic [NUM_BTN-1:0] BTN_LEVEL,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE
);

  // Last count value before a transition qualifies; cnt never goes past it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] sync_s1;
  logic [NUM_BTN-1:0] sync_s2;

  // Two-flop synchroniser; only sync_s2 is allowed to reach the FSMs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= BTN_IN;
      sync_s2 <= sync_s1;
    end
  end

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // State, counter and registered outputs for this button.
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Next-state: count consecutive opposite samples, any bounce restarts from the settled state.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (sync_s2[b]) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sync_s2[b]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!sync_s2[b]) begin
            state_d = REL_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        REL_WAIT: begin
          if (sync_s2[b]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign BTN_LEVEL[b]   = level_q;
    assign BTN_PRESS[b]   = press_q;
    assign BTN_RELEASE[b] = release_q;
  end

endmodule
